// File: rtl/lc3_mem_sequencer_pkg.sv
// lc3_mem_sequencer_pkg
//   Shared definitions for the LC-3 memory-access sequencer: opcode
//   enumeration, per-opcode memory access counts (fetch included),
//   sequencer state type and the TRAP vector base.
//   Optional feature macro used by the RTL: MEM_TIMEOUT_EN.
package lc3_mem_sequencer_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'd0,
        OP_ADD  = 4'd1,
        OP_LD   = 4'd2,
        OP_ST   = 4'd3,
        OP_JSR  = 4'd4,
        OP_AND  = 4'd5,
        OP_LDR  = 4'd6,
        OP_STR  = 4'd7,
        OP_RTI  = 4'd8,
        OP_NOT  = 4'd9,
        OP_LDI  = 4'd10,
        OP_STI  = 4'd11,
        OP_JMP  = 4'd12,
        OP_RES  = 4'd13,
        OP_LEA  = 4'd14,
        OP_TRAP = 4'd15
    } opcode_e;

    // Total memory accesses per opcode, indexed by opcode value.
    localparam logic [1:0] OP_ACCESSES [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2,   // BR  ADD LD  ST
        2'd1, 2'd1, 2'd2, 2'd2,   // JSR AND LDR STR
        2'd2, 2'd1, 2'd3, 2'd3,   // RTI NOT LDI STI
        2'd1, 2'd1, 2'd1, 2'd2    // JMP RES LEA TRAP
    };

    localparam logic [7:0] TRAP_BASE = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_IND,
        S_IND_GAP,
        S_DATA,
        S_DONE
    } seq_state_e;

    function automatic logic is_store(input opcode_e op);
        return op inside {OP_ST, OP_STR, OP_STI};
    endfunction

endpackage

// File: rtl/lc3_mem_port.sv
// lc3_mem_port
//   Registered memory-port front end for the sequencer. An issue pulse
//   loads address/direction/data and raises mem_req; everything is held
//   until the acknowledging cycle, then mem_req, mem_we and mem_wdata drop.
//   Optional watchdog (MEM_TIMEOUT_EN) abandons a request after
//   TIMEOUT_CYCLES request cycles without an acknowledge.
// Ports:
//   clock, reset        clock, synchronous active-high reset
//   issue, issue_*      start a new access (address, write flag, data)
//   mem_ack             memory acknowledge (ignored without mem_req)
//   mem_req/we/addr/wdata  registered memory request outputs
//   ack_ok              mem_ack qualified by an outstanding request
//   expire              watchdog expiry in this cycle (0 when disabled)
//   timeout_err         registered expiry pulse (MEM_TIMEOUT_EN only)
module lc3_mem_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue,
    input  logic [15:0] issue_addr,
    input  logic        issue_we,
    input  logic [15:0] issue_wdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        ack_ok,
    output logic        expire
`ifdef MEM_TIMEOUT_EN
    ,
    output logic        timeout_err
`endif
);

    assign ack_ok = mem_req && mem_ack;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;

    // Counter holds the number of completed un-acked request cycles, so the
    // last allowed cycle is the one where it equals TIMEOUT_CYCLES-1.
    assign expire = mem_req && !mem_ack && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= expire;
            if (!mem_req || mem_ack || issue || expire)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (issue) begin
            mem_req   <= 1'b1;
            mem_we    <= issue_we;
            mem_addr  <= issue_addr;
            mem_wdata <= issue_we ? issue_wdata : '0;
        end else if (ack_ok || expire) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end
    end

endmodule

// File: rtl/lc3_mem_sequencer.sv
// lc3_mem_sequencer
//   Per-instruction LC-3 memory-access sequencer: fetches the instruction,
//   decodes the opcode and issues 1, 2 or 3 memory accesses in total.
//   Optional feature macro: MEM_TIMEOUT_EN (adds watchdog and timeout_err).
// Ports:
//   clock, reset           clock, synchronous active-high reset
//   start, pc              begin instruction at pc (ignored while busy)
//   ea_in, store_data      effective address / store data, sampled in DECODE
//   mem_req/we/addr/wdata  memory request (registered, held until ack)
//   mem_rdata, mem_ack     memory response
//   ir, mdr                fetched instruction, last data read
//   busy, instr_done       in-progress flag, one-cycle completion pulse
//   access_cnt             accesses completed for the current instruction
//   timeout_err            watchdog pulse (MEM_TIMEOUT_EN only)
module lc3_mem_sequencer
    import lc3_mem_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] pc,
    input  logic [15:0] ea_in,
    input  logic [15:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] ir,
    output logic [15:0] mdr,
    output logic        busy,
    output logic        instr_done,
    output logic [1:0]  access_cnt
`ifdef MEM_TIMEOUT_EN
    ,
    output logic        timeout_err
`endif
);

    seq_state_e state, state_n;
    opcode_e    op;
    logic [15:0] ptr_q, sd_q;
    logic        issue, issue_we, ack_ok, expire;
    logic [15:0] issue_addr, issue_wdata;

    assign op = opcode_e'(ir[15:12]);

    lc3_mem_port #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_port (
        .clock       (clock),
        .reset       (reset),
        .issue       (issue),
        .issue_addr  (issue_addr),
        .issue_we    (issue_we),
        .issue_wdata (issue_wdata),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .ack_ok      (ack_ok),
        .expire      (expire)
`ifdef MEM_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    // Accesses are issued on the transition into FETCH/IND/DATA so the
    // registered mem_req is already high in the first cycle of the state.
    always_comb begin
        state_n     = state;
        issue       = 1'b0;
        issue_addr  = '0;
        issue_we    = 1'b0;
        issue_wdata = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n    = S_FETCH;
                    issue      = 1'b1;
                    issue_addr = pc;
                end
            end
            S_FETCH: begin
                if (ack_ok) state_n = S_DECODE;
            end
            S_DECODE: begin
                case (OP_ACCESSES[ir[15:12]])
                    2'd2: begin
                        state_n     = S_DATA;
                        issue       = 1'b1;
                        issue_addr  = (op == OP_TRAP) ? {TRAP_BASE, ir[7:0]} : ea_in;
                        issue_we    = is_store(op);
                        issue_wdata = store_data;
                    end
                    2'd3: begin
                        state_n    = S_IND;
                        issue      = 1'b1;
                        issue_addr = ea_in;
                    end
                    default: state_n = S_DONE;
                endcase
            end
            S_IND: begin
                if (ack_ok) state_n = S_IND_GAP;
            end
            S_IND_GAP: begin
                state_n     = S_DATA;
                issue       = 1'b1;
                issue_addr  = ptr_q;
                issue_we    = is_store(op);
                issue_wdata = sd_q;
            end
            S_DATA: begin
                if (ack_ok) state_n = S_DONE;
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        // Watchdog expiry abandons the instruction without passing DONE.
        if (expire) begin
            state_n = S_IDLE;
            issue   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            ir         <= '0;
            mdr        <= '0;
            busy       <= 1'b0;
            instr_done <= 1'b0;
            access_cnt <= '0;
            ptr_q      <= '0;
            sd_q       <= '0;
        end else begin
            state      <= state_n;
            busy       <= (state_n != S_IDLE);
            instr_done <= (state_n == S_DONE);
            if (state == S_IDLE && start)
                access_cnt <= '0;
            else if (ack_ok)
                access_cnt <= access_cnt + 2'd1;
            if (state == S_FETCH && ack_ok)
                ir <= mem_rdata;
            if (state == S_DECODE)
                sd_q <= store_data;
            if (state == S_IND && ack_ok)
                ptr_q <= mem_rdata;
            if (state == S_DATA && ack_ok && !mem_we)
                mdr <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_lc3_mem_sequencer.sv
// tb_lc3_mem_sequencer
//   Scoreboard bench for lc3_mem_sequencer. A behavioural model turns each
//   instruction into its list of expected memory accesses and a completion
//   record; a monitor compares the DUT against these queues. A memory
//   responder inserts planned wait cycles and stray acks outside requests.
//   Build with MEM_TIMEOUT_EN to also exercise the watchdog.
module tb_lc3_mem_sequencer;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } acc_t;

    typedef struct {
        int unsigned lat;
        logic [15:0] mdr;
        logic [1:0]  cnt;
        logic [15:0] ir;
    } done_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] pc = '0, ea_in = '0, store_data = '0;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] ir, mdr;
    logic        busy, instr_done;
    logic [1:0]  access_cnt;
`ifdef MEM_TIMEOUT_EN
    logic        timeout_err;
    int unsigned to_count = 0;
`endif

    lc3_mem_sequencer #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .pc         (pc),
        .ea_in      (ea_in),
        .store_data (store_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .ir         (ir),
        .mdr        (mdr),
        .busy       (busy),
        .instr_done (instr_done),
        .access_cnt (access_cnt)
`ifdef MEM_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int unsigned n_checks = 0, n_pass = 0;
    acc_t        exp_acc[$];
    done_t       exp_done[$];
    int unsigned waits[$];
    logic [15:0] mem [logic [15:0]];
    logic [15:0] model_mdr = '0;
    int unsigned start_cyc = 0;
    logic        in_req = 1'b0;
    int unsigned wait_left = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic unexpected(input string name, input logic [31:0] got);
        n_checks++;
        $display("FAIL %s: got %0h expected nothing (cycle %0d)", name, got, cyc);
    endtask

    // Memory: planned waits per access, stray acks when idle.
    always @(posedge clock) begin
        #1;
        if (reset) begin
            mem_ack = 1'b0;
            in_req  = 1'b0;
        end else if (mem_req) begin
            if (!in_req) begin
                in_req    = 1'b1;
                wait_left = (waits.size() > 0) ? waits.pop_front() : 0;
            end
            if (wait_left == 0) begin
                if (mem_we) mem[mem_addr] = mem_wdata;
                mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : ~mem_addr;
                mem_ack   = 1'b1;
                in_req    = 1'b0;
            end else begin
                wait_left--;
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
            end
        end else begin
            in_req    = 1'b0;
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = 16'($urandom);
        end
    end

    // Monitor: every request cycle must match the head expected access.
    always @(negedge clock) begin
        acc_t  a;
        done_t d;
        if (!reset) begin
            if (mem_req) begin
                if (exp_acc.size() == 0) unexpected("access", mem_addr);
                else begin
                    a = exp_acc[0];
                    chk("acc_addr", mem_addr, a.addr);
                    chk("acc_we", mem_we, a.we);
                    chk("acc_wdata", mem_wdata, a.wdata);
                    if (mem_ack) a = exp_acc.pop_front();
                end
            end
            if (instr_done) begin
                if (exp_done.size() == 0) unexpected("instr_done", ir);
                else begin
                    d = exp_done.pop_front();
                    chk("latency", cyc - start_cyc, d.lat);
                    chk("done_ir", ir, d.ir);
                    chk("done_mdr", mdr, d.mdr);
                    chk("done_cnt", access_cnt, d.cnt);
                    chk("done_busy", busy, 1);
                end
            end
`ifdef MEM_TIMEOUT_EN
            if (timeout_err) to_count++;
`endif
        end
    end

    function automatic int unsigned n_access(input logic [3:0] op);
        case (op)
            4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd15: return 2;
            4'd10, 4'd11:                        return 3;
            default:                             return 1;
        endcase
    endfunction

    // Reference model: expected accesses, memory contents and completion.
    task automatic model_instr(input logic [15:0] pc_v, ir_v, ea_v, sd_v, val_v, ptr_v,
                               input int unsigned w0, w1, w2);
        acc_t        a;
        done_t       d;
        int unsigned n, lat;
        logic [3:0]  op;
        logic [15:0] daddr;
        op = ir_v[15:12];
        n  = n_access(op);
        mem[pc_v] = ir_v;
        a.we = 1'b0; a.addr = pc_v; a.wdata = '0;
        exp_acc.push_back(a); waits.push_back(w0);
        lat = 3 + w0;
        if (n >= 2) begin
            if (n == 3) begin
                mem[ea_v] = ptr_v;
                a.we = 1'b0; a.addr = ea_v; a.wdata = '0;
                exp_acc.push_back(a); waits.push_back(w1);
                daddr = ptr_v;
                a.we  = (op == 4'd11);
                waits.push_back(w2);
                lat += 3 + w1 + w2;
            end else begin
                daddr = (op == 4'd15) ? {8'h00, ir_v[7:0]} : ea_v;
                a.we  = (op == 4'd3 || op == 4'd7);
                waits.push_back(w1);
                lat += 1 + w1;
            end
            a.addr  = daddr;
            a.wdata = a.we ? sd_v : 16'h0;
            if (!a.we) begin
                mem[daddr] = val_v;
                model_mdr  = val_v;
            end
            exp_acc.push_back(a);
        end
        d.lat = lat; d.mdr = model_mdr; d.cnt = 2'(n); d.ir = ir_v;
        exp_done.push_back(d);
    endtask

    task automatic issue_start(input logic [15:0] pc_v, ea_v, sd_v);
        int unsigned g;
        @(posedge clock); #1;
        g = 0;
        while (busy && g < 100) begin @(posedge clock); #1; g++; end
        pc = pc_v; ea_in = ea_v; store_data = sd_v;
        start = 1'b1; start_cyc = cyc;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Runs to completion; stray starts while busy (including DONE) must be ignored.
    task automatic run_instr(input logic [15:0] pc_v, ir_v, ea_v, sd_v, val_v, ptr_v,
                             input int unsigned w0, w1, w2);
        int unsigned g;
        model_instr(pc_v, ir_v, ea_v, sd_v, val_v, ptr_v, w0, w1, w2);
        issue_start(pc_v, ea_v, sd_v);
        g = 0;
        while (busy && g < 200) begin
            start = instr_done ? 1'($urandom) : ($urandom_range(0, 3) == 0);
            pc    = 16'($urandom);
            @(posedge clock); #1; g++;
        end
        start = 1'b0;
        chk("complete_in_time", (g < 200), 1);
        chk("all_accesses_seen", exp_acc.size(), 0);
        chk("done_seen", exp_done.size(), 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_ir"}, ir, 0);
        chk({tag, "_mdr"}, mdr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_instr_done"}, instr_done, 0);
        chk({tag, "_access_cnt"}, access_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int unsigned g;
        logic [3:0]  op;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_reset_state("reset");
`ifdef MEM_TIMEOUT_EN
        chk("reset_timeout_err", timeout_err, 0);
`endif
        @(posedge clock); #1;
        reset = 1'b0;

        // Directed cases
        run_instr(16'h3000, 16'h1042, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        run_instr(16'h3000, 16'h2005, 16'h3006, 16'h0000, 16'hBEEF, 16'h0000, 0, 0, 0);
        run_instr(16'h3000, 16'hB002, 16'h4000, 16'h1234, 16'h0000, 16'h5000, 0, 0, 0);
        run_instr(16'h3000, 16'hF025, 16'h4444, 16'h0000, 16'hCAFE, 16'h0000, 2, 2, 0);

        // Reset while a DATA write is waiting for its ack
        model_instr(16'h3010, 16'h3007, 16'h4010, 16'h9999, 16'h0000, 16'h0000, 0, 3, 0);
        issue_start(16'h3010, 16'h4010, 16'h9999);
        g = 0;
        while (!(mem_req && mem_we) && g < 50) begin @(posedge clock); #1; g++; end
        chk("write_pending", mem_req && mem_we, 1);
        reset = 1'b1;
        @(posedge clock); #2;
        exp_acc.delete(); exp_done.delete(); waits.delete();
        model_mdr = '0;
        @(negedge clock);
        chk_reset_state("midreset");
        @(posedge clock); #1;
        reset = 1'b0;
        run_instr(16'h3020, 16'h6123, 16'h4020, 16'h0000, 16'h7777, 16'h0000, 1, 0, 0);

        // Randomised instruction stream
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom);
            run_instr(16'h3000 | 16'($urandom_range(0, 16'h0FFF)),
                      {op, 12'($urandom)},
                      16'h4000 | 16'($urandom_range(0, 16'h0FFF)),
                      16'($urandom), 16'($urandom),
                      16'h5000 | 16'($urandom_range(0, 16'h0FFF)),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

`ifdef MEM_TIMEOUT_EN
        // Fetch never acknowledged: watchdog fires after 4 request cycles
        begin
            acc_t a;
            mem[16'h3100] = 16'h1042;
            a.we = 1'b0; a.addr = 16'h3100; a.wdata = '0;
            exp_acc.push_back(a); waits.push_back(1000);
            issue_start(16'h3100, 16'h0000, 16'h0000);
            g = 0;
            while (!timeout_err && g < 50) begin @(posedge clock); #1; g++; end
            chk("timeout_cycle", cyc - start_cyc, 5);
            chk("timeout_busy", busy, 0);
            chk("timeout_mem_req", mem_req, 0);
            chk("timeout_no_done", instr_done, 0);
            exp_acc.delete(); waits.delete();
            repeat (3) @(posedge clock);
            #1;
            chk("timeout_pulse_count", to_count, 1);
        end
        run_instr(16'h3200, 16'h2001, 16'h4200, 16'h0000, 16'h1357, 16'h0000, 0, 0, 0);
`endif

        repeat (3) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lc3_mem_sequencer.md
# lc3_mem_sequencer

Per-instruction memory-access sequencer for the LC-3 core. It fetches the instruction word, decodes its opcode, and issues the exact number of memory cycles that opcode requires: 1, 2 or 3, including the fetch. It sits between the LC-3 control/datapath and the single shared memory port, and is the block the environment's memory-transaction monitor checks against.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: watchdog limit in cycles per access; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clock  in  1  system clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a new instruction; ignored while busy=1.
- pc  in  16  fetch address; sampled when start is accepted.
- ea_in  in  16  effective address from the datapath; sampled in DECODE.
- store_data  in  16  write data for ST/STR/STI; sampled in DECODE.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  16  access address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data; valid while mem_ack=1.
- mem_ack  in  1  access complete.
- ir  out  16  fetched instruction word.
- mdr  out  16  last data read.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- instr_done  out  1  one-cycle pulse in DONE.
- access_cnt  out  2  accesses completed for the current instruction.
- timeout_err  out  1  one-cycle pulse on watchdog expiry; exists only with MEM_TIMEOUT_EN.

## Operation
- States: IDLE, FETCH, DECODE, IND, IND_GAP, DATA, DONE.
- IDLE: on start=1, latch pc and go to FETCH.
- FETCH: read at the latched pc. On ack, ir <= mem_rdata and go to DECODE.
- DECODE: one cycle. Opcode = ir[15:12]. Sample ea_in and store_data.
- Required total accesses per opcode:
  - 1 access (fetch only): BR, ADD, JSR, AND, NOT, JMP, RES, LEA. Go to DONE.
  - 2 accesses: LD, LDR, RTI (read at ea_in); TRAP (read at {8'h00, ir[7:0]}); ST, STR (write store_data at ea_in). Go to DATA.
  - 3 accesses: LDI, STI. Go to IND and read the pointer at ea_in.
- IND: on ack, latch the pointer, go to IND_GAP, then DATA. DATA reads (LDI) or writes (STI) at the pointer.
- DATA: on ack, a read loads mdr <= mem_rdata; go to DONE.
- DONE: instr_done=1 for one cycle, then IDLE.
- mem_wdata is valid only when mem_we=1 and is 0 otherwise.
- access_cnt increments on each ack, wraps never (maximum is 3), and clears on start acceptance.

## Timing
- Reset values: mem_req, mem_we, mem_addr, mem_wdata, ir, mdr, busy, instr_done, access_cnt and timeout_err are all 0; state is IDLE.
- All outputs are registered.
- mem_req is high only in FETCH, IND and DATA. It is held with mem_addr, mem_we and mem_wdata stable until the cycle in which mem_ack=1.
- After any ack, mem_req is 0 for at least one cycle; DECODE and IND_GAP provide this gap.
- mem_ack outside a request is ignored.
- Latency with a zero-wait memory (ack in the first request cycle), start sampled in cycle 0:
  - 1-access opcodes: instr_done in cycle 3.
  - 2-access opcodes: instr_done in cycle 4.
  - 3-access opcodes: instr_done in cycle 6.
- Each wait cycle on an access adds one cycle.
- A start asserted in the same cycle as instr_done is ignored; the next start is accepted in IDLE.
- Reset mid-operation, including with mem_req high: the next edge forces IDLE and all outputs to their reset values. The outstanding access is abandoned.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter runs while mem_req=1 and clears on ack.
  - When it reaches TIMEOUT_CYCLES without an ack: drop mem_req, pulse timeout_err, skip DONE (no instr_done), and return to IDLE.
- MEM_TIMEOUT_EN undefined: no counter, no timeout_err port; the block waits indefinitely for mem_ack.

## Structure
- Shared package (EnvironmentPkg side and RTL package):
  - Opcode enum (BR=0 … TRAP=15).
  - Per-opcode access-count constant (1/2/3, as listed above).
  - Sequencer state typedef.
  - TRAP vector base 8'h00.
- One sub-module, lc3_mem_port: owns mem_req/mem_addr/mem_we/mem_wdata hold-until-ack, the post-ack gap, and the optional watchdog.

## Test plan
- ADD (ir=16'h1042), pc=16'h3000, zero-wait memory -> one read at 3000; instr_done in cycle 3; access_cnt=1.
- LD (ir=16'h2005), ea_in=16'h3006, rdata 16'hBEEF -> reads at 3000 and 3006; mdr=BEEF; instr_done in cycle 4.
- STI (ir=16'hB002), ea_in=16'h4000, pointer 16'h5000, store_data=16'h1234 -> reads at 3000 and 4000, then a write of 1234 to 5000; access_cnt=3; instr_done in cycle 6.
- TRAP x25 (ir=16'hF025) with 2 wait cycles on each ack -> second read at 0025; mem_addr stable throughout each wait; instr_done in cycle 8.
- Reset asserted while a DATA write is pending -> the next cycle has mem_req=0, busy=0, state IDLE; a start afterwards fetches normally.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and mem_ack never asserted -> timeout_err pulses after 4 request cycles; no instr_done; mem_req=0; busy=0.
